// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer holding the
// 16-bit accumulator A and the halt state.
// Optional carry flag and JC opcode when CONTROL_UNIT_CARRY_EN is defined.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_inst             instruction word from program_counter
//   o_pc_inc/o_pc_load one-cycle PC strobes; o_pc_addr jump target
//   o_ram_addr/o_ram_load/o_ram_data  data ram write side
//   i_ram_data         data ram read data (one cycle after address)
//   o_acc, o_halted, o_carry  architectural state
module control_unit #(
    parameter int INST_ADDR_WIDTH = 8,
    parameter int DATA_ADDR_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [15:0]                i_inst,
    output logic                       o_pc_inc,
    output logic                       o_pc_load,
    output logic [INST_ADDR_WIDTH-1:0] o_pc_addr,
    output logic [DATA_ADDR_WIDTH-1:0] o_ram_addr,
    output logic                       o_ram_load,
    output logic [15:0]                o_ram_data,
    input  logic [15:0]                i_ram_data,
    output logic [15:0]                o_acc,
    output logic                       o_halted,
    output logic                       o_carry
);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_WAIT,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_ADVANCE,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [15:0] r_acc;
    logic [15:0] w_acc_d;
    logic        w_acc_we;
    logic        w_ir_we;
    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic        w_jc_taken;
    logic        w_take;
    logic        w_unused;

    assign w_op       = r_ir[15:12];
    assign w_imm      = r_ir[7:0];
    assign w_unused   = &{1'b0, r_ir[11:8]};
    assign o_pc_addr  = r_ir[INST_ADDR_WIDTH-1:0];
    assign o_ram_addr = r_ir[DATA_ADDR_WIDTH-1:0];
    assign o_ram_data = r_acc;
    assign o_acc      = r_acc;
    assign o_halted   = (r_state == S_HALT);

`ifdef CONTROL_UNIT_CARRY_EN
    logic        r_carry;
    logic [16:0] w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, i_ram_data};
    assign w_jc_taken = r_carry;
    assign o_carry    = r_carry;

    // Carry tracks only the most recent ADD/SUB, written as A is.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_carry <= 1'b0;
        end else if (r_state == S_MEM) begin
            if (w_op == OP_ADD) begin
                r_carry <= w_sum[16];
            end else if (w_op == OP_SUB) begin
                r_carry <= (r_acc < i_ram_data);
            end
        end
    end
`else
    assign w_jc_taken = 1'b0;
    assign o_carry    = 1'b0;
`endif

    // Branch decision is made in DECODE from the current A / C.
    assign w_take = (w_op == OP_JMP)
                  | ((w_op == OP_JZ) & (r_acc == 16'h0000))
                  | ((w_op == OP_JC) & w_jc_taken);

    always_comb begin
        w_next     = r_state;
        w_ir_we    = 1'b0;
        w_acc_we   = 1'b0;
        w_acc_d    = r_acc;
        o_pc_inc   = 1'b0;
        o_pc_load  = 1'b0;
        o_ram_load = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                w_next = S_ADVANCE;
                case (w_op)
                    OP_LD, OP_ADD, OP_SUB: begin
                        w_next = S_MEM;
                    end
                    OP_ST: begin
                        o_ram_load = 1'b1;
                    end
                    OP_LDI: begin
                        w_acc_we = 1'b1;
                        w_acc_d  = {8'h00, w_imm};
                    end
                    OP_HALT: begin
                        w_next = S_HALT;
                    end
                    default: begin
                        // JMP/JZ/JC taken skip ADVANCE; anything
                        // else not listed above behaves as NOP.
                        if (w_take) begin
                            o_pc_load = 1'b1;
                            w_next    = S_WAIT;
                        end
                    end
                endcase
            end
            S_MEM: begin
                w_acc_we = 1'b1;
                w_next   = S_ADVANCE;
                case (w_op)
                    OP_ADD:  w_acc_d = r_acc + i_ram_data;
                    OP_SUB:  w_acc_d = r_acc - i_ram_data;
                    default: w_acc_d = i_ram_data;
                endcase
            end
            S_ADVANCE: begin
                o_pc_inc = 1'b1;
                w_next   = S_WAIT;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_acc   <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_ir_we) begin
                r_ir <= i_inst;
            end
            if (w_acc_we) begin
                r_acc <= w_acc_d;
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: control_unit with a program_counter/rom/ram model and
// an ISA-level scoreboard of expected strobe events.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inst;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_addr;
    logic [7:0]  ram_addr;
    logic        ram_load;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] acc;
    logic        halted;
    logic        carry;

    logic [15:0] prog  [256];
    logic [15:0] ram   [256];
    logic [15:0] m_ram [256];
    logic [7:0]  pc;
    int          cyc = 0;
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

`ifdef CONTROL_UNIT_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    localparam logic [2:0] K_INC = 3'b001;
    localparam logic [2:0] K_LD  = 3'b010;
    localparam logic [2:0] K_ST  = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
        int          gap;
    } ev_t;

    ev_t         sb [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_st;
    int          last_t;
    int          hc;
    logic [15:0] e_acc;
    logic        e_c;
    logic        e_halt;

    control_unit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_inst     (inst),
        .o_pc_inc   (pc_inc),
        .o_pc_load  (pc_load),
        .o_pc_addr  (pc_addr),
        .o_ram_addr (ram_addr),
        .o_ram_load (ram_load),
        .o_ram_data (ram_wdata),
        .i_ram_data (ram_rdata),
        .o_acc      (acc),
        .o_halted   (halted),
        .o_carry    (carry)
    );

    always #5 clk = ~clk;

    // program_counter + sync rom: i_inst follows a PC strobe by two edges
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) pc <= 8'd0;
        else if (pc_load) pc <= pc_addr;
        else if (pc_inc) pc <= pc + 8'd1;
        inst <= prog[pc];
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (ram_load) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(logic [2:0] k, logic [7:0] a,
                               logic [15:0] d, int g);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.gap  = g;
        return e;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        m_ram[a] = d;
        pl_addr  = a;
        pl_data  = d;
        pl_we    = 1'b1;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic begin_rst();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic end_rst();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", acc, 0);
        chk("rst_strobes", {ram_load, pc_load, pc_inc}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_carry", carry, 0);
        rst_n  = 1'b1;
        last_t = cyc - 1;
    endtask

    // ISA model: strobe events with the gap since the previous strobe
    task automatic predict();
        logic [15:0] a;
        logic [16:0] s;
        logic        c;
        logic [7:0]  p;
        logic [15:0] ir;
        a = 16'h0000;
        c = 1'b0;
        p = 8'd0;
        e_halt = 1'b0;
        sb.delete();
        for (int n = 0; n < 64 && !e_halt; n++) begin
            ir = prog[p];
            case (ir[15:12])
                4'h1: begin
                    a = {8'h00, ir[7:0]};
                    sb.push_back(mk(K_INC, 0, 0, 4));
                    p++;
                end
                4'h2: begin
                    a = m_ram[ir[7:0]];
                    sb.push_back(mk(K_INC, 0, 0, 5));
                    p++;
                end
                4'h3: begin
                    m_ram[ir[7:0]] = a;
                    sb.push_back(mk(K_ST, ir[7:0], a, 3));
                    sb.push_back(mk(K_INC, 0, 0, 1));
                    p++;
                end
                4'h4, 4'h5: begin
                    if (ir[15:12] == 4'h4) begin
                        s = {1'b0, a} + {1'b0, m_ram[ir[7:0]]};
                        c = s[16];
                    end else begin
                        c = a < m_ram[ir[7:0]];
                        s = {1'b0, a - m_ram[ir[7:0]]};
                    end
                    a = s[15:0];
                    sb.push_back(mk(K_INC, 0, 0, 5));
                    p++;
                end
                4'h6, 4'h7, 4'h8: begin
                    if (ir[15:12] == 4'h6 ||
                        (ir[15:12] == 4'h7 && a == 16'h0000) ||
                        (ir[15:12] == 4'h8 && CEN && c)) begin
                        sb.push_back(mk(K_LD, ir[7:0], 0, 3));
                        p = ir[7:0];
                    end else begin
                        sb.push_back(mk(K_INC, 0, 0, 4));
                        p++;
                    end
                end
                4'hF: e_halt = 1'b1;
                default: begin
                    sb.push_back(mk(K_INC, 0, 0, 4));
                    p++;
                end
            endcase
        end
        e_acc = a;
        e_c   = CEN ? c : 1'b0;
    endtask

    task automatic run(input int budget, input int abort_at);
        logic [2:0] s;
        ev_t        e;
        hc   = 0;
        n_st = 0;
        for (int k = 0; k < budget; k++) begin
            s = {ram_load, pc_load, pc_inc};
            if (s != 3'b000) begin
                chk("excl", $countones(s), 1);
                if (s[2]) n_st++;
                if (sb.size() == 0) begin
                    chk("extra_strobe", {29'd0, s}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("kind", {29'd0, s}, {29'd0, e.kind});
                    chk("gap", cyc - last_t, e.gap);
                    if (e.kind == K_ST) begin
                        chk("st_addr", ram_addr, e.addr);
                        chk("st_data", ram_wdata, e.data);
                    end
                    if (e.kind == K_LD) chk("jmp_tgt", pc_addr, e.addr);
                end
                last_t = cyc;
            end
            if (halted) begin
                hc = k + 1;
                break;
            end
            if (k == abort_at) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_prog(input string tag);
        chk({tag, "_halted"}, halted, e_halt);
        chk({tag, "_acc"}, acc, e_acc);
        chk({tag, "_carry"}, carry, e_c);
        chk({tag, "_sb_left"}, sb.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk({tag, "_quiet"}, {ram_load, pc_load, pc_inc}, 0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pl_we   = 1'b0;
        pl_addr = 8'd0;
        pl_data = 16'h0000;
        for (int i = 0; i < 256; i++) m_ram[i] = 16'h0000;

        // LDI 0x2A; HALT
        clear_prog();
        prog[0] = 16'h102A;
        begin_rst();
        end_rst();
        predict();
        run(200, -1);
        chk("t1_halt_by10", (hc > 0 && hc <= 10), 1);
        finish_prog("t1");

        // LDI 5; ST 0x10; LDI 0; LD 0x10
        clear_prog();
        prog[0] = 16'h1005;
        prog[1] = 16'h3010;
        prog[2] = 16'h1000;
        prog[3] = 16'h2010;
        begin_rst();
        poke(8'h10, 16'h1234);
        end_rst();
        predict();
        run(200, -1);
        chk("t2_st_count", n_st, 1);
        chk("t2_ram10", ram[8'h10], 16'h0005);
        finish_prog("t2");

        // ADD wrap: 2 + 0xFFFF
        clear_prog();
        prog[0] = 16'h1002;
        prog[1] = 16'h4001;
        begin_rst();
        poke(8'h01, 16'hFFFF);
        end_rst();
        predict();
        run(200, -1);
        chk("t3_wrap", acc, 16'h0001);
        finish_prog("t3");

        // SUB borrow then JC 6
        clear_prog();
        prog[0] = 16'h1003;
        prog[1] = 16'h5002;
        prog[2] = 16'h8006;
        prog[4] = 16'h1011;
        begin_rst();
        poke(8'h02, 16'h0005);
        end_rst();
        predict();
        run(200, -1);
        finish_prog("t4");

        // JZ taken
        clear_prog();
        prog[0] = 16'h1000;
        prog[1] = 16'h7008;
        prog[2] = 16'h1077;
        begin_rst();
        end_rst();
        predict();
        run(200, -1);
        finish_prog("t5");

        // JZ not taken
        clear_prog();
        prog[0] = 16'h1001;
        prog[1] = 16'h7008;
        prog[8] = 16'h1055;
        begin_rst();
        end_rst();
        predict();
        run(200, -1);
        finish_prog("t6");

        // unused opcode 0xC as NOP
        clear_prog();
        prog[0] = 16'h1033;
        prog[1] = 16'hC0FF;
        begin_rst();
        end_rst();
        predict();
        run(200, -1);
        chk("t7_acc_kept", acc, 16'h0033);
        finish_prog("t7");

        // reset in MEM of ADD, then clean rerun
        clear_prog();
        prog[0] = 16'h1002;
        prog[1] = 16'h4001;
        begin_rst();
        poke(8'h01, 16'hFFFF);
        end_rst();
        predict();
        run(200, 7);
        chk("t8_pre_acc", acc, 16'h0002);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t8_mid_acc", acc, 0);
        chk("t8_mid_strobes", {ram_load, pc_load, pc_inc}, 0);
        chk("t8_mid_halted", halted, 0);
        end_rst();
        predict();
        run(200, -1);
        finish_prog("t8");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
